// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and the rotating-priority search used by the mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] index;
  } pick_t;

  // Walk from the highest offset down so the lowest offset from ptr is written last and wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
    pick_t      res;
    logic [1:0] idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        res.found = 1'b1;
        res.index = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_m41.sv
// 1-bit 4:1 mux; input d1 is reached with s1 set, d2 with s0 set.
module m41 (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic s0,
  input  logic s1,
  output logic y
);

  always_comb begin
    y = d0;
    case ({s0, s1})
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin sharing of one m41 among four requesters, with a bounded hold per grant
// and a registered, qualified copy of the selected data bit.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic             s0,
  output logic             s1,
  output logic             dout,
  output logic             dout_vld
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e           state_q;
  logic [1:0]       owner_q;
  logic [1:0]       ptr_q;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic [N_REQ-1:0] gnt_q;
  logic             s0_q;
  logic             s1_q;
  logic             dout_q;
  logic             dout_d;
  logic             vld_q;

  logic [N_REQ-1:0] others;
  logic             releaseNow;
  pick_t            idlePick;
  pick_t            handPick;

  always_comb begin
    others     = req & ~(4'b0001 << owner_q);
    releaseNow = !req[owner_q] || ((cnt_q == HOLD_LAST) && (others != '0));
    idlePick   = rr_pick(req, ptr_q);
    handPick   = rr_pick(others, owner_q + 2'd1);
    cnt_d      = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + 4'd1;
  end

  // A handover goes straight to the next owner so the mux never sees an idle bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idlePick.found) begin
            state_q <= BUSY;
            owner_q <= idlePick.index;
            gnt_q   <= 4'b0001 << idlePick.index;
            s1_q    <= idlePick.index[0];
            s0_q    <= idlePick.index[1];
            cnt_q   <= 4'd0;
          end
        end
        BUSY: begin
          if (releaseNow) begin
            ptr_q <= owner_q + 2'd1;
            if (handPick.found) begin
              owner_q <= handPick.index;
              gnt_q   <= 4'b0001 << handPick.index;
              s1_q    <= handPick.index[0];
              s0_q    <= handPick.index[1];
              cnt_q   <= 4'd0;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  m41 u_m41 (
    .d0 (d[0]),
    .d1 (d[1]),
    .d2 (d[2]),
    .d3 (d[3]),
    .s0 (s0_q),
    .s1 (s1_q),
    .y  (dout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= |gnt_q;
    end
  end

  assign gnt      = gnt_q;
  assign s0       = s0_q;
  assign s1       = s1_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: two arbiters (hold limits 4 and 1) share stimulus; a reference model
// predicts each edge's outputs into per-DUT queues that a monitor drains after every edge.
module tb_mux4_rr_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       dout;
    logic       vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;

  logic [3:0] gntA, gntB;
  logic       s0A, s1A, doutA, vldA;
  logic       s0B, s1B, doutB, vldB;

  int   numChecks = 0;
  int   numErrors = 0;
  exp_t expQ0[$];
  exp_t expQ1[$];

  // Model state per DUT: owner -1 means idle, held counts cycles the owner has had the grant.
  int   mOwner[2];
  int   mHeld[2];
  int   mPrio[2];
  logic mS0[2];
  logic mS1[2];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(4)) u_hold4 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gntA), .s0(s0A), .s1(s1A), .dout(doutA), .dout_vld(vldA)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1)) u_hold1 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gntB), .s0(s0B), .s1(s1B), .dout(doutB), .dout_vld(vldB)
  );

  function automatic int holdOf(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int firstFrom(input logic [3:0] r, input int start);
    for (int off = 0; off < 4; off++) begin
      if (r[(start + off) % 4]) return (start + off) % 4;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [3:0] act,
                             input logic [3:0] exp);
    numChecks++;
    if (act !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s dut%0d at %0t: got %b, expected %b", name, k, $time, act, exp);
    end
  endtask

  task automatic compareDut(input int k, input exp_t e);
    if (k == 0) begin
      checkOutput("gnt", k, gntA, e.gnt);
      checkOutput("s1s0", k, {2'b00, s1A, s0A}, {2'b00, e.s1, e.s0});
      checkOutput("dout", k, {3'b000, doutA}, {3'b000, e.dout});
      checkOutput("dout_vld", k, {3'b000, vldA}, {3'b000, e.vld});
    end else begin
      checkOutput("gnt", k, gntB, e.gnt);
      checkOutput("s1s0", k, {2'b00, s1B, s0B}, {2'b00, e.s1, e.s0});
      checkOutput("dout", k, {3'b000, doutB}, {3'b000, e.dout});
      checkOutput("dout_vld", k, {3'b000, vldB}, {3'b000, e.vld});
    end
  endtask

  task automatic checkResetState();
    exp_t z;
    z.gnt = 4'b0000; z.s0 = 1'b0; z.s1 = 1'b0; z.dout = 1'b0; z.vld = 1'b0;
    compareDut(0, z);
    compareDut(1, z);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mOwner[k] = -1;
      mHeld[k]  = 0;
      mPrio[k]  = 0;
      mS0[k]    = 1'b0;
      mS1[k]    = 1'b0;
    end
  endtask

  // Predict what the DUT shows after the coming rising edge, given req/d now on the pins.
  task automatic modelStep(input int k, output exp_t e);
    logic [3:0] others;
    int         sel;
    sel    = (mS0[k] ? 2 : 0) + (mS1[k] ? 1 : 0);
    e.dout = d[sel];
    e.vld  = (mOwner[k] >= 0);
    if (mOwner[k] < 0) begin
      mOwner[k] = firstFrom(req, mPrio[k]);
      mHeld[k]  = 1;
    end else begin
      others = req;
      others[mOwner[k]] = 1'b0;
      if (!req[mOwner[k]] || (mHeld[k] >= holdOf(k) && others != 4'b0000)) begin
        mPrio[k]  = (mOwner[k] + 1) % 4;
        mOwner[k] = firstFrom(others, mPrio[k]);
        mHeld[k]  = 1;
      end else begin
        mHeld[k]++;
      end
    end
    if (mOwner[k] >= 0) begin
      e.gnt  = 4'(1 << mOwner[k]);
      mS1[k] = (mOwner[k] % 2) == 1;
      mS0[k] = (mOwner[k] / 2) == 1;
    end else begin
      e.gnt = 4'b0000;
    end
    e.s0 = mS0[k];
    e.s1 = mS1[k];
  endtask

  task automatic driveAndModel(input logic [3:0] reqV, input logic [3:0] dV);
    exp_t e;
    req = reqV;
    d   = dV;
    modelStep(0, e);
    expQ0.push_back(e);
    modelStep(1, e);
    expQ1.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] reqV, input logic [3:0] dV);
    @(negedge clk);
    driveAndModel(reqV, dV);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ0.size() > 0) begin
        e = expQ0.pop_front();
        compareDut(0, e);
      end
      if (expQ1.size() > 0) begin
        e = expQ1.pop_front();
        compareDut(1, e);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] curReq;
    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b0000;
    modelReset();
    #2;
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
    driveAndModel(4'b0001, 4'b0001);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 4'b0001);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 4'($urandom_range(0, 15)));

    for (int i = 0; i < 20; i++) applyStimulus(4'b1111, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 4'($urandom_range(0, 15)));

    for (int i = 0; i < 10; i++) applyStimulus(4'b0100, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 3; i++) applyStimulus(4'b0110, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 4'($urandom_range(0, 15)));

    for (int i = 0; i < 2; i++) applyStimulus(4'b0100, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 2; i++) applyStimulus(4'b1101, 4'($urandom_range(0, 15)));
    applyStimulus(4'b1001, 4'($urandom_range(0, 15)));
    applyStimulus(4'b0001, 4'($urandom_range(0, 15)));
    applyStimulus(4'b0011, 4'b0001);
    applyStimulus(4'b0011, 4'b0010);
    applyStimulus(4'b0011, 4'b0011);
    applyStimulus(4'b0011, 4'b0000);

    // Asynchronous reset in the middle of a busy grant, sampled before the next edge.
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 4'($urandom_range(0, 15)));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState();
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    driveAndModel(4'b1111, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 4'($urandom_range(0, 15)));

    curReq = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) curReq = 4'($urandom_range(0, 15));
      applyStimulus(curReq, 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    numChecks++;
    if (expQ0.size() != 0 || expQ1.size() != 0) begin
      numErrors++;
      $display("[TB] FAIL drain: got %0d/%0d pending, expected 0/0", expQ0.size(), expQ1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
